sram32_ctrl: RTL

Bridges the 32-bit opc7 CPU data bus to the 16-bit asynchronous external SRAM on the BlackIce board. It sits between the CPU bus decode and the top-level SB_IO data pins and SRAM control pins. Each 32-bit access becomes two sequenced 16-bit SRAM cycles: low half first, then high half. The block signals completion with a one-cycle `ready` pulse, which the system uses to stall `cpuclken`.

---
 rtl/sram32_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram32_ctrl.sv
// 32-bit CPU bus to 16-bit asynchronous SRAM bridge: each word is two sequenced halfword cycles, low half first.
// Optional macro SRAM_POSTED_WRITE_EN: writes acknowledge one cycle after acceptance and complete in the background.
module sram32_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req,
    input  logic        rnw,
    input  logic [16:0] address,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        busy,
    output logic [17:0] ram_adr,
    output logic        ram_cs_b,
    output logic        ram_oe_b,
    output logic        ram_we_b,
    output logic [15:0] ram_dout,
    output logic        ram_dout_en,
    input  logic [15:0] ram_din
);

`ifdef SRAM_POSTED_WRITE_EN
    localparam logic POSTED_WR = 1'b1;
`else
    localparam logic POSTED_WR = 1'b0;
`endif

    localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q;
    logic        half_q;
    logic [3:0]  cnt_q;
    logic        rnw_q;
    logic [16:0] addr_q;
    logic [15:0] din_hi_q;
    logic [15:0] lo_q;
    logic [31:0] dout_q;
    logic        ready_q;
    logic        busy_q;
    logic [17:0] ram_adr_q;
    logic        ram_cs_b_q;
    logic        ram_oe_b_q;
    logic        ram_we_b_q;
    logic [15:0] ram_dout_q;
    logic        ram_dout_en_q;

    // Every pin-facing signal is a flop, so the SRAM strobes never glitch.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= IDLE;
            half_q        <= 1'b0;
            cnt_q         <= 4'd0;
            rnw_q         <= 1'b1;
            addr_q        <= 17'd0;
            din_hi_q      <= 16'd0;
            lo_q          <= 16'd0;
            dout_q        <= 32'd0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            ram_adr_q     <= 18'd0;
            ram_cs_b_q    <= 1'b1;
            ram_oe_b_q    <= 1'b1;
            ram_we_b_q    <= 1'b1;
            ram_dout_q    <= 16'd0;
            ram_dout_en_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        rnw_q         <= rnw;
                        addr_q        <= address;
                        din_hi_q      <= din[31:16];
                        half_q        <= 1'b0;
                        state_q       <= SETUP;
                        busy_q        <= 1'b1;
                        ram_adr_q     <= {address, 1'b0};
                        ram_cs_b_q    <= 1'b0;
                        ram_oe_b_q    <= 1'b1;
                        ram_we_b_q    <= 1'b1;
                        ram_dout_en_q <= !rnw;
                        ready_q       <= POSTED_WR & !rnw;
                        if (!rnw) begin
                            ram_dout_q <= din[15:0];
                        end
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= STROBE_LAST;
                    if (rnw_q) begin
                        ram_oe_b_q <= 1'b0;
                    end else begin
                        ram_we_b_q <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= HOLD;
                        ram_oe_b_q <= 1'b1;
                        ram_we_b_q <= 1'b1;
                        // Low half is parked so dout only changes once the full word is in.
                        if (rnw_q) begin
                            if (half_q) begin
                                dout_q <= {ram_din, lo_q};
                            end else begin
                                lo_q <= ram_din;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (!half_q) begin
                        half_q    <= 1'b1;
                        state_q   <= SETUP;
                        ram_adr_q <= {addr_q, 1'b1};
                        if (!rnw_q) begin
                            ram_dout_q <= din_hi_q;
                        end
                    end else begin
                        state_q       <= DONE;
                        ram_cs_b_q    <= 1'b1;
                        ram_dout_en_q <= 1'b0;
                        ready_q       <= rnw_q | !POSTED_WR;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout        = dout_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign ram_adr     = ram_adr_q;
    assign ram_cs_b    = ram_cs_b_q;
    assign ram_oe_b    = ram_oe_b_q;
    assign ram_we_b    = ram_we_b_q;
    assign ram_dout    = ram_dout_q;
    assign ram_dout_en = ram_dout_en_q;

endmodule
